// File: rtl/aximm_stream_pkg.sv
// Shared definitions for the AXI-MM-over-stream tunnel. The same message
// format is used by the stream server at the far end of the link.
package aximm_stream_pkg;

    // Message geometry: one 256-bit beat made of eight 32-bit words
    localparam int AXIS_W    = 256;
    localparam int WORD_W    = 32;
    localparam int MSG_WORDS = AXIS_W / WORD_W;

    // Message types carried in word 0
    localparam logic [31:0] MT_READ_REQ  = 32'd1;
    localparam logic [31:0] MT_WRITE_REQ = 32'd2;
    localparam logic [31:0] MT_READ_RSP  = 32'd3;
    localparam logic [31:0] MT_WRITE_RSP = 32'd4;

    // Word indices inside a message
    localparam int MF_TYPE    = 0;
    localparam int MF_ADDR_LO = 1;
    localparam int MF_ADDR_HI = 2;
    localparam int MF_DATA    = 3;
    localparam int MF_RESP    = 4;

    // Completion used when the far end never answers
    localparam logic [1:0]  RESP_SLVERR   = 2'b10;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    // Client transaction states
    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } client_state_t;

    // Assemble a request message; unused words stay zero
    function automatic logic [AXIS_W-1:0] build_req(
        input logic [31:0] mtype,
        input logic [63:0] addr,
        input logic [31:0] data
    );
        logic [AXIS_W-1:0] pkt;
        pkt = '0;
        pkt[MF_TYPE*WORD_W    +: WORD_W] = mtype;
        pkt[MF_ADDR_LO*WORD_W +: WORD_W] = addr[31:0];
        pkt[MF_ADDR_HI*WORD_W +: WORD_W] = addr[63:32];
        pkt[MF_DATA*WORD_W    +: WORD_W] = data;
        return pkt;
    endfunction

endpackage

// File: rtl/axil_slave_front.sv
// AXI-Lite slave front end: captures AW, W and AR into holding registers,
// drives the READY lines and picks which held request goes out next.
module axil_slave_front #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              init,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    output logic              wready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    input  logic              issue,
    input  logic              b_done,
    input  logic              r_done,
    output logic              req_valid,
    output logic              req_is_write,
    output logic [63:0]       req_addr,
    output logic [DATA_W-1:0] req_data
);

    logic [ADDR_W-1:0] aw_addr_reg;
    logic [DATA_W-1:0] w_data_reg;
    logic [ADDR_W-1:0] ar_addr_reg;
    logic              aw_held_reg;
    logic              w_held_reg;
    logic              ar_held_reg;
    logic              awready_reg;
    logic              wready_reg;
    logic              arready_reg;
    logic              prio_write_reg;

    logic write_ready;
    logic read_ready;
    logic grant_write;

    assign write_ready = aw_held_reg && w_held_reg;
    assign read_ready  = ar_held_reg;
    // Contention goes to whichever kind lost the previous contention
    assign grant_write = write_ready && (!read_ready || prio_write_reg);

    assign req_valid    = write_ready || read_ready;
    assign req_is_write = grant_write;
    assign req_addr     = grant_write ? 64'(aw_addr_reg) : 64'(ar_addr_reg);
    assign req_data     = w_data_reg;

    assign awready = awready_reg;
    assign wready  = wready_reg;
    assign arready = arready_reg;

    // Capture channels independently; READYs reopen only when the matching response completes
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_addr_reg    <= '0;
            w_data_reg     <= '0;
            ar_addr_reg    <= '0;
            aw_held_reg    <= 1'b0;
            w_held_reg     <= 1'b0;
            ar_held_reg    <= 1'b0;
            awready_reg    <= 1'b0;
            wready_reg     <= 1'b0;
            arready_reg    <= 1'b0;
            prio_write_reg <= 1'b1;
        end else begin
            if (init) begin
                awready_reg <= 1'b1;
                wready_reg  <= 1'b1;
                arready_reg <= 1'b1;
            end
            if (awvalid && awready_reg) begin
                aw_addr_reg <= awaddr;
                aw_held_reg <= 1'b1;
                awready_reg <= 1'b0;
            end
            if (wvalid && wready_reg) begin
                w_data_reg  <= wdata;
                w_held_reg  <= 1'b1;
                wready_reg  <= 1'b0;
            end
            if (arvalid && arready_reg) begin
                ar_addr_reg <= araddr;
                ar_held_reg <= 1'b1;
                arready_reg <= 1'b0;
            end
            if (b_done) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                awready_reg <= 1'b1;
                wready_reg  <= 1'b1;
            end
            if (r_done) begin
                ar_held_reg <= 1'b0;
                arready_reg <= 1'b1;
            end
            if (issue && write_ready && read_ready) begin
                prio_write_reg <= !grant_write;
            end
        end
    end

endmodule

// File: rtl/aximm_over_stream_client.sv
// AXI-Lite slave that tunnels each access as one request beat on AXIS TX and
// completes it from the matching response beat on AXIS RX. One in flight.
module aximm_over_stream_client
    import aximm_stream_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH  = 64,
    parameter int          AXI_DATA_WIDTH  = 32,
    parameter int          AXIS_DATA_WIDTH = 256,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [AXI_ADDR_WIDTH-1:0]  S_AXI_AWADDR,
    input  logic [2:0]                 S_AXI_AWPROT,
    input  logic                       S_AXI_AWVALID,
    output logic                       S_AXI_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]  S_AXI_WDATA,
    input  logic [3:0]                 S_AXI_WSTRB,
    input  logic                       S_AXI_WVALID,
    output logic                       S_AXI_WREADY,
    output logic [1:0]                 S_AXI_BRESP,
    output logic                       S_AXI_BVALID,
    input  logic                       S_AXI_BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0]  S_AXI_ARADDR,
    input  logic [2:0]                 S_AXI_ARPROT,
    input  logic                       S_AXI_ARVALID,
    output logic                       S_AXI_ARREADY,
    output logic [AXI_DATA_WIDTH-1:0]  S_AXI_RDATA,
    output logic [1:0]                 S_AXI_RRESP,
    output logic                       S_AXI_RVALID,
    input  logic                       S_AXI_RREADY,
    output logic [AXIS_DATA_WIDTH-1:0] AXIS_TX_TDATA,
    output logic                       AXIS_TX_TVALID,
    output logic                       AXIS_TX_TLAST,
    input  logic                       AXIS_TX_TREADY,
    input  logic [AXIS_DATA_WIDTH-1:0] AXIS_RX_TDATA,
    input  logic                       AXIS_RX_TVALID,
    input  logic                       AXIS_RX_TLAST,
    output logic                       AXIS_RX_TREADY
);

    // Timer limit widened by one bit so the compare never wraps
    localparam logic [32:0] TIMEOUT_LIM = {1'b0, 32'(TIMEOUT_CYCLES)};

    client_state_t              state_reg;
    logic                       cur_write_reg;
    logic [63:0]                cur_addr_reg;
    logic [AXIS_DATA_WIDTH-1:0] tx_tdata_reg;
    logic                       tx_tvalid_reg;
    logic                       tx_tlast_reg;
    logic                       rx_tready_reg;
    logic                       bvalid_reg;
    logic [1:0]                 bresp_reg;
    logic                       rvalid_reg;
    logic [1:0]                 rresp_reg;
    logic [AXI_DATA_WIDTH-1:0]  rdata_reg;
    logic [31:0]                timer_reg;

    logic                      req_valid;
    logic                      req_is_write;
    logic [63:0]               req_addr;
    logic [AXI_DATA_WIDTH-1:0] req_data;
    logic                      issue;
    logic                      b_done;
    logic                      r_done;

    logic [31:0] rx_word [MSG_WORDS];
    logic        rx_beat;
    logic        rx_match;
    logic        timeout_hit;
    logic [31:0] exp_rsp_type;
    logic        unused_bits;

    // Split the response beat into its 32-bit message words
    for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_rx_word
        assign rx_word[gi] = AXIS_RX_TDATA[gi*WORD_W +: WORD_W];
    end

    assign issue  = (state_reg == ST_IDLE) && req_valid;
    assign b_done = bvalid_reg && S_AXI_BREADY;
    assign r_done = rvalid_reg && S_AXI_RREADY;

    assign exp_rsp_type = cur_write_reg ? MT_WRITE_RSP : MT_READ_RSP;
    assign rx_beat      = AXIS_RX_TVALID && rx_tready_reg;
    assign rx_match     = rx_beat && (rx_word[MF_TYPE] == exp_rsp_type)
                          && ({rx_word[MF_ADDR_HI], rx_word[MF_ADDR_LO]} == cur_addr_reg);
    // Fires on the WAIT cycle whose increment would bring the timer to the limit
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (({1'b0, timer_reg} + 33'd1) >= TIMEOUT_LIM);

    // Protection, strobes, TLAST and the padding words carry nothing this end needs
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, AXIS_RX_TLAST,
                           rx_word[MF_RESP][31:2], rx_word[5], rx_word[6], rx_word[7]};

    axil_slave_front #(
        .ADDR_W (AXI_ADDR_WIDTH),
        .DATA_W (AXI_DATA_WIDTH)
    ) u_front (
        .clk          (clk),
        .resetn       (resetn),
        .init         (state_reg == ST_INIT),
        .awaddr       (S_AXI_AWADDR),
        .awvalid      (S_AXI_AWVALID),
        .awready      (S_AXI_AWREADY),
        .wdata        (S_AXI_WDATA),
        .wvalid       (S_AXI_WVALID),
        .wready       (S_AXI_WREADY),
        .araddr       (S_AXI_ARADDR),
        .arvalid      (S_AXI_ARVALID),
        .arready      (S_AXI_ARREADY),
        .issue        (issue),
        .b_done       (b_done),
        .r_done       (r_done),
        .req_valid    (req_valid),
        .req_is_write (req_is_write),
        .req_addr     (req_addr),
        .req_data     (req_data)
    );

    assign AXIS_TX_TDATA  = tx_tdata_reg;
    assign AXIS_TX_TVALID = tx_tvalid_reg;
    assign AXIS_TX_TLAST  = tx_tlast_reg;
    assign AXIS_RX_TREADY = rx_tready_reg;
    assign S_AXI_BVALID   = bvalid_reg;
    assign S_AXI_BRESP    = bresp_reg;
    assign S_AXI_RVALID   = rvalid_reg;
    assign S_AXI_RRESP    = rresp_reg;
    assign S_AXI_RDATA    = rdata_reg;

    // Transaction FSM: issue request, wait for matching response or timeout, complete on B/R
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg     <= ST_INIT;
            cur_write_reg <= 1'b0;
            cur_addr_reg  <= '0;
            tx_tdata_reg  <= '0;
            tx_tvalid_reg <= 1'b0;
            tx_tlast_reg  <= 1'b0;
            rx_tready_reg <= 1'b0;
            bvalid_reg    <= 1'b0;
            bresp_reg     <= 2'b00;
            rvalid_reg    <= 1'b0;
            rresp_reg     <= 2'b00;
            rdata_reg     <= '0;
            timer_reg     <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    // RX is drained continuously so stale beats never block the link
                    rx_tready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        cur_write_reg <= req_is_write;
                        cur_addr_reg  <= req_addr;
                        tx_tdata_reg  <= build_req(req_is_write ? MT_WRITE_REQ : MT_READ_REQ,
                                                   req_addr, req_is_write ? req_data : 32'h0);
                        tx_tvalid_reg <= 1'b1;
                        tx_tlast_reg  <= 1'b1;
                        state_reg     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (AXIS_TX_TREADY) begin
                        tx_tvalid_reg <= 1'b0;
                        tx_tlast_reg  <= 1'b0;
                        timer_reg     <= '0;
                        state_reg     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (timer_reg != '1) begin
                        timer_reg <= timer_reg + 32'd1;
                    end
                    if (rx_match) begin
                        if (cur_write_reg) begin
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= rx_word[MF_RESP][1:0];
                        end else begin
                            rvalid_reg <= 1'b1;
                            rresp_reg  <= rx_word[MF_RESP][1:0];
                            rdata_reg  <= rx_word[MF_DATA];
                        end
                        state_reg <= ST_RESP;
                    end else if (timeout_hit) begin
                        if (cur_write_reg) begin
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= RESP_SLVERR;
                        end else begin
                            rvalid_reg <= 1'b1;
                            rresp_reg  <= RESP_SLVERR;
                            rdata_reg  <= TIMEOUT_RDATA;
                        end
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cur_write_reg ? S_AXI_BREADY : S_AXI_RREADY) begin
                        bvalid_reg <= 1'b0;
                        rvalid_reg <= 1'b0;
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

endmodule
